// File: rtl/mux_scan_multi_if.sv
// Signal bundle for mux_scan_multi: control inputs, the packed input words and the
// registered output path. master drives the controls, slave is the multiplexer.
interface mux_scan_multi_if #(
    parameter int WIDTH  = 4,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2,
    parameter int NUM_CH = 2
);
    logic                            mode;
    logic [SEL_W-1:0]                sel_in;
    logic                            sel_load;
    logic                            hold;
    logic [NUM_CH*NUM_IN*WIDTH-1:0]  in_bus;
    logic [NUM_CH*WIDTH-1:0]         out_bus;
    logic [SEL_W-1:0]                sel_cur;
    logic [NUM_IN-1:0]               slot_oh;
    logic                            slot_stb;

    modport master (
        output mode, sel_in, sel_load, hold, in_bus,
        input  out_bus, sel_cur, slot_oh, slot_stb
    );

    modport slave (
        input  mode, sel_in, sel_load, hold, in_bus,
        output out_bus, sel_cur, slot_oh, slot_stb
    );
endinterface

// File: rtl/mux_scan_multi.sv
// N-input, multi-channel registered multiplexer with a manual select register and a
// prescaled round-robin scan mode; emits a one-hot slot enable and a new-slot strobe.
module mux_scan_multi #(
    parameter int WIDTH    = 4,
    parameter int NUM_IN   = 4,
    parameter int SEL_W    = 2,
    parameter int NUM_CH   = 2,
    parameter int PRESCALE = 16,
    parameter int PS_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    mux_scan_multi_if.slave  bus
);

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_IN - 1);

    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [PS_W-1:0]         cnt, cnt_d;
    logic                    load_ok;

    logic [NUM_CH*WIDTH-1:0] out_q, out_d;
    logic [SEL_W-1:0]        cur_q;
    logic [NUM_IN-1:0]       oh_q;
    logic                    stb_q;

    // sel_load is a single-cycle command; out-of-range selects are dropped so
    // sel_q can never address a non-existent input.
    assign load_ok = bus.sel_load && (int'(bus.sel_in) < NUM_IN);

    always_comb begin
        sel_d = sel_q;
        cnt_d = cnt;
        if (load_ok) begin
            sel_d = bus.sel_in;
            cnt_d = '0;
        end else if (!bus.mode) begin
            cnt_d = '0;
        end else if (!bus.hold) begin
            if (cnt == PS_LAST) begin
                cnt_d = '0;
                sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
            end else begin
                cnt_d = cnt + PS_W'(1);
            end
        end
    end

    always_comb begin
        out_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            out_d[c*WIDTH +: WIDTH] = bus.in_bus[(c*NUM_IN + int'(sel_q))*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= '0;
            cnt   <= '0;
        end else begin
            sel_q <= sel_d;
            cnt   <= cnt_d;
        end
    end

    // cur_q lags sel_q by one cycle, so a difference marks the first output cycle of a new slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            cur_q <= '0;
            oh_q  <= '0;
            stb_q <= 1'b0;
        end else begin
            out_q <= out_d;
            cur_q <= sel_q;
            oh_q  <= NUM_IN'(1) << sel_q;
            stb_q <= (sel_q != cur_q);
        end
    end

    assign bus.out_bus  = out_q;
    assign bus.sel_cur  = cur_q;
    assign bus.slot_oh  = oh_q;
    assign bus.slot_stb = stb_q;

endmodule

// File: tb/tb_mux_scan_multi.sv
// Bench for mux_scan_multi: two instances (4 inputs / prescale 4, 3 inputs / prescale 1)
// checked every cycle against a slot-level reference model, plus directed literal checks.
module tb_mux_scan_multi;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_scan_multi_if #(.WIDTH(4), .NUM_IN(4), .SEL_W(2), .NUM_CH(2)) ia ();
    mux_scan_multi_if #(.WIDTH(4), .NUM_IN(3), .SEL_W(2), .NUM_CH(2)) ib ();

    mux_scan_multi #(.WIDTH(4), .NUM_IN(4), .SEL_W(2), .NUM_CH(2), .PRESCALE(4), .PS_W(16))
        dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    mux_scan_multi #(.WIDTH(4), .NUM_IN(3), .SEL_W(2), .NUM_CH(2), .PRESCALE(1), .PS_W(16))
        dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: current slot, cycles elapsed in the slot, and what the
    // outputs must show after the most recent clock edge.
    int         m_sel [2];
    int         m_ph  [2];
    bit         m_chg [2];
    logic [7:0] e_out [2];
    int         e_cur [2];
    logic [3:0] e_oh  [2];
    bit         e_stb [2];
    bit         e_valid = 1'b0;

    task automatic model_step(input int k, input int nin, input int ps, input bit r,
                              input bit md, input bit ld, input int si, input bit hd,
                              input logic [31:0] ibus);
        int nxt;
        if (r) begin
            m_sel[k] = 0; m_ph[k] = 0; m_chg[k] = 1'b0;
            e_out[k] = '0; e_cur[k] = 0; e_oh[k] = '0; e_stb[k] = 1'b0;
            return;
        end
        e_out[k] = {ibus[(nin + m_sel[k])*4 +: 4], ibus[m_sel[k]*4 +: 4]};
        e_cur[k] = m_sel[k];
        e_oh[k]  = 4'(1 << m_sel[k]);
        e_stb[k] = m_chg[k];
        nxt = m_sel[k];
        if (ld && si < nin) begin
            nxt = si;
            m_ph[k] = 0;
        end else if (md && !hd) begin
            m_ph[k]++;
            if (m_ph[k] == ps) begin
                m_ph[k] = 0;
                nxt = (m_sel[k] + 1) % nin;
            end
        end
        if (!md) m_ph[k] = 0;
        m_chg[k] = (nxt != m_sel[k]);
        m_sel[k] = nxt;
    endtask

    always @(posedge clk) begin
        model_step(0, 4, 4, rst, ia.mode, ia.sel_load, int'(ia.sel_in), ia.hold, ia.in_bus);
        model_step(1, 3, 1, rst, ib.mode, ib.sel_load, int'(ib.sel_in), ib.hold, {8'h00, ib.in_bus});
        e_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (e_valid) begin
            chk("a_out",  32'(ia.out_bus),  32'(e_out[0]));
            chk("a_cur",  32'(ia.sel_cur),  32'(e_cur[0]));
            chk("a_oh",   32'(ia.slot_oh),  32'(e_oh[0]));
            chk("a_stb",  32'(ia.slot_stb), 32'(e_stb[0]));
            chk("b_out",  32'(ib.out_bus),  32'(e_out[1]));
            chk("b_cur",  32'(ib.sel_cur),  32'(e_cur[1]));
            chk("b_oh",   32'(ib.slot_oh),  32'(e_oh[1] & 4'h7));
            chk("b_stb",  32'(ib.slot_stb), 32'(e_stb[1]));
        end
    end

    initial begin
        int s;
        logic [3:0] hi, lo;
        rst = 1'b1;
        ia.mode = 1'b1; ia.sel_in = '0; ia.sel_load = 1'b0; ia.hold = 1'b0;
        ia.in_bus = 32'hDCBA_4321;
        ib.mode = 1'b1; ib.sel_in = '0; ib.sel_load = 1'b0; ib.hold = 1'b0;
        ib.in_bus = 24'hCBA321;
        tick(3);
        rst = 1'b0;

        // Scan after reset: A holds each slot 4 cycles, B advances every cycle.
        for (int n = 1; n <= 16; n++) begin
            tick(1);
            s  = ((n - 1) / 4) % 4;
            hi = 4'(10 + s);
            lo = 4'(s + 1);
            chk("lit_a_scan_out", 32'(ia.out_bus), 32'({hi, lo}));
            chk("lit_a_scan_oh",  32'(ia.slot_oh), 32'(1 << s));
            chk("lit_a_scan_stb", 32'(ia.slot_stb), 32'((n > 1 && (n - 1) % 4 == 0) ? 1 : 0));
            s  = (n - 1) % 3;
            hi = 4'(10 + s);
            lo = 4'(s + 1);
            chk("lit_b_scan_out", 32'(ib.out_bus), 32'({hi, lo}));
            chk("lit_b_scan_stb", 32'(ib.slot_stb), 32'((n > 1) ? 1 : 0));
        end

        // Manual load of 2 on A, then reload of the same value.
        ia.mode = 1'b0; ia.sel_load = 1'b1; ia.sel_in = 2'd2; ib.mode = 1'b0;
        tick(1);
        ia.sel_load = 1'b0;
        tick(1);
        chk("lit_man_out", 32'(ia.out_bus), 32'h0000_00C3);
        chk("lit_man_cur", 32'(ia.sel_cur), 32'd2);
        chk("lit_man_stb", 32'(ia.slot_stb), 32'd1);
        ia.sel_load = 1'b1; ia.sel_in = 2'd2;
        tick(1);
        ia.sel_load = 1'b0;
        tick(1);
        chk("lit_reload_stb", 32'(ia.slot_stb), 32'd0);
        chk("lit_reload_cur", 32'(ia.sel_cur), 32'd2);

        // Invalid select on B (NUM_IN=3); A loads 1 then starts scanning.
        ib.sel_load = 1'b1; ib.sel_in = 2'd3;
        ia.sel_load = 1'b1; ia.sel_in = 2'd1;
        tick(1);
        ib.sel_load = 1'b0; ia.sel_load = 1'b0; ia.mode = 1'b1;
        tick(1);
        chk("lit_inval_cur", 32'(ib.sel_cur), 32'd1);
        chk("lit_inval_out", 32'(ib.out_bus), 32'h0000_00B2);
        chk("lit_inval_stb", 32'(ib.slot_stb), 32'd0);

        // Hold for 10 cycles at slot 1 with an input change during the hold.
        tick(1);
        ia.hold = 1'b1;
        tick(5);
        ia.in_bus[7:4] = 4'h9;
        tick(1);
        chk("lit_hold_track", 32'(ia.out_bus[3:0]), 32'h9);
        chk("lit_hold_cur", 32'(ia.sel_cur), 32'd1);
        tick(4);
        ia.hold = 1'b0; ia.in_bus[7:4] = 4'h2;
        tick(2);
        chk("lit_unhold_cur1", 32'(ia.sel_cur), 32'd1);
        tick(1);
        chk("lit_unhold_cur2", 32'(ia.sel_cur), 32'd2);
        chk("lit_unhold_stb", 32'(ia.slot_stb), 32'd1);

        // Load 0 in the cycle the prescaler would advance slot 2.
        tick(2);
        ia.sel_load = 1'b1; ia.sel_in = 2'd0;
        tick(1);
        ia.sel_load = 1'b0;
        tick(1);
        chk("lit_ldscan_cur", 32'(ia.sel_cur), 32'd0);
        chk("lit_ldscan_stb", 32'(ia.slot_stb), 32'd1);
        tick(3);
        chk("lit_ldscan_hold0", 32'(ia.sel_cur), 32'd0);
        tick(1);
        chk("lit_ldscan_next", 32'(ia.sel_cur), 32'd1);

        // Reset mid-slot (slot 3, two cycles in), then a full first slot.
        tick(9);
        rst = 1'b1;
        tick(1);
        chk("lit_rst_out", 32'(ia.out_bus), 32'd0);
        chk("lit_rst_oh",  32'(ia.slot_oh), 32'd0);
        rst = 1'b0;
        tick(1);
        chk("lit_rel_oh", 32'(ia.slot_oh), 32'd1);
        tick(3);
        chk("lit_rel_slot0", 32'(ia.sel_cur), 32'd0);
        tick(1);
        chk("lit_rel_slot1", 32'(ia.sel_cur), 32'd1);

        // Randomized traffic on both instances.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) ia.mode = ~ia.mode;
            if ($urandom_range(0, 19) == 0) ib.mode = ~ib.mode;
            ia.sel_load = ($urandom_range(0, 9) == 0);
            ib.sel_load = ($urandom_range(0, 9) == 0);
            ia.sel_in   = 2'($urandom_range(0, 3));
            ib.sel_in   = 2'($urandom_range(0, 3));
            ia.hold     = ($urandom_range(0, 4) == 0);
            ib.hold     = ($urandom_range(0, 4) == 0);
            ia.in_bus   = $urandom;
            ib.in_bus   = 24'($urandom);
            tick(1);
        end
        rst = 1'b0;
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
